axil_master_bridge: RTL and testbench

- Single-outstanding AXI-lite master (initiator).
- Converts a simple command/response stream from fabric logic into AXI-lite read or write transactions.
- Mates directly to the team's AXI-lite BRAM responder and register slaves, so fabric-side sequencers can load and read back waveform/config memory without the PS.
- Reads and writes are strictly serialized: one transaction in flight, never concurrent.

---
 rtl/axil_master_bridge.sv | 228 ++++++++++++++++++++++
 tb/tb_axil_master_bridge.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/axil_master_bridge.sv
// rtl/axil_master_bridge.sv - single-outstanding AXI-lite master driven by a command/response stream
// Optional handshake watchdog: define AXIL_MASTER_TIMEOUT_EN.
module axil_master_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    axi_clock,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic [2:0]              m_axil_awprot,
  output logic                    m_axil_awvalid,
  input  logic                    m_axil_awready,
  output logic [DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                    m_axil_wvalid,
  input  logic                    m_axil_wready,
  input  logic [1:0]              m_axil_bresp,
  input  logic                    m_axil_bvalid,
  output logic                    m_axil_bready,
  output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic [2:0]              m_axil_arprot,
  output logic                    m_axil_arvalid,
  input  logic                    m_axil_arready,
  input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]              m_axil_rresp,
  input  logic                    m_axil_rvalid,
  output logic                    m_axil_rready
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_n;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_n;
  logic                    awvalid_q, awvalid_n;
  logic                    wvalid_q, wvalid_n;
  logic                    bready_q, bready_n;
  logic                    arvalid_q, arvalid_n;
  logic                    rready_q, rready_n;
  logic                    cmd_ready_q, cmd_ready_n;
  logic                    rsp_valid_q, rsp_valid_n;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_n;
  logic [1:0]              resp_q, resp_n;
  logic                    timeout_q, timeout_n;
  logic                    aw_done, w_done;

  // A channel counts as done once its valid has dropped or is handshaking now.
  assign aw_done = !awvalid_q || m_axil_awready;
  assign w_done  = !wvalid_q || m_axil_wready;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt, wd_cnt_n;
  logic          busy;

  assign busy = (state == WR_REQ) || (state == WR_RESP) ||
                (state == RD_ADDR) || (state == RD_DATA);

  always_ff @(posedge axi_clock) begin
    if (rst) wd_cnt <= '0;
    else     wd_cnt <= wd_cnt_n;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge axi_clock) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      resp_q      <= 2'b00;
      timeout_q   <= 1'b0;
    end else begin
      state       <= state_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      wstrb_q     <= wstrb_n;
      awvalid_q   <= awvalid_n;
      wvalid_q    <= wvalid_n;
      bready_q    <= bready_n;
      arvalid_q   <= arvalid_n;
      rready_q    <= rready_n;
      cmd_ready_q <= cmd_ready_n;
      rsp_valid_q <= rsp_valid_n;
      rdata_q     <= rdata_n;
      resp_q      <= resp_n;
      timeout_q   <= timeout_n;
    end
  end

  always_comb begin
    state_n     = state;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    wstrb_n     = wstrb_q;
    awvalid_n   = awvalid_q;
    wvalid_n    = wvalid_q;
    bready_n    = bready_q;
    arvalid_n   = arvalid_q;
    rready_n    = rready_q;
    cmd_ready_n = cmd_ready_q;
    rsp_valid_n = rsp_valid_q;
    rdata_n     = rdata_q;
    resp_n      = resp_q;
    timeout_n   = timeout_q;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_n      = cmd_addr;
          wdata_n     = cmd_wdata;
          wstrb_n     = cmd_wstrb;
          cmd_ready_n = 1'b0;
          timeout_n   = 1'b0;
          if (cmd_we) begin
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            state_n   = WR_REQ;
          end else begin
            arvalid_n = 1'b1;
            state_n   = RD_ADDR;
          end
        end
      end
      WR_REQ: begin
        if (awvalid_q && m_axil_awready) awvalid_n = 1'b0;
        if (wvalid_q && m_axil_wready)   wvalid_n  = 1'b0;
        if (aw_done && w_done) begin
          bready_n = 1'b1;
          state_n  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axil_bvalid) begin
          resp_n      = m_axil_bresp;
          rdata_n     = '0;
          bready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          state_n     = RSP;
        end
      end
      RD_ADDR: begin
        if (m_axil_arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_axil_rvalid) begin
          rdata_n     = m_axil_rdata;
          resp_n      = m_axil_rresp;
          rready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          state_n     = RSP;
        end
      end
      RSP: begin
        // A command presented in this cycle waits: cmd_ready is still low.
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          cmd_ready_n = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
    wd_cnt_n = '0;
    if (busy && state_n == state) wd_cnt_n = wd_cnt + 1'b1;
    if (busy && wd_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
      awvalid_n   = 1'b0;
      wvalid_n    = 1'b0;
      bready_n    = 1'b0;
      arvalid_n   = 1'b0;
      rready_n    = 1'b0;
      rsp_valid_n = 1'b1;
      rdata_n     = '0;
      resp_n      = 2'b10;
      timeout_n   = 1'b1;
      wd_cnt_n    = '0;
      state_n     = RSP;
    end
`endif
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rdata_q;
  assign rsp_resp       = resp_q;
  assign rsp_timeout    = timeout_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_axil_master_bridge.sv
// tb/tb_axil_master_bridge.sv - randomized self-checking bench for axil_master_bridge
// Cycle-stepped slave with programmable latencies; reference memory model checks read-back.
`timescale 1ns/1ps
module tb_axil_master_bridge;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int SW = DW / 8;

  logic          axi_clock = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] m_axil_awaddr, m_axil_araddr;
  logic [2:0]    m_axil_awprot, m_axil_arprot;
  logic          m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [DW-1:0] m_axil_wdata, m_axil_rdata;
  logic [SW-1:0] m_axil_wstrb;
  logic [1:0]    m_axil_bresp, m_axil_rresp;
  logic          m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic          m_axil_rvalid, m_axil_rready;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] ref_mem [0:1023];
  logic [DW-1:0] slv_mem [0:1023];

  always #5 axi_clock = ~axi_clock;

  axil_master_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(1024)) dut (
    .axi_clock(axi_clock), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot), .m_axil_awvalid(m_axil_awvalid),
    .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb), .m_axil_wvalid(m_axil_wvalid),
    .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot), .m_axil_arvalid(m_axil_arvalid),
    .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
    .m_axil_rready(m_axil_rready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b0; m_axil_bresp = 2'b00;
    m_axil_arready = 1'b0; m_axil_rvalid = 1'b0; m_axil_rdata = '0; m_axil_rresp = 2'b00;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
    check({tag, "_valids"}, 64'({m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, rsp_valid}), 64'(0));
    check({tag, "_readies"}, 64'({m_axil_bready, m_axil_rready}), 64'(0));
    check({tag, "_rsp"}, 64'({rsp_rdata, rsp_resp, rsp_timeout}), 64'(0));
    check({tag, "_axi_addr"}, 64'({m_axil_awaddr, m_axil_araddr, m_axil_wstrb}), 64'(0));
  endtask

  // Runs one command; called and returning on a negedge.
  // lat_a: aw (or ar) ready delay, lat_w: w ready delay, lat_r: b/r valid delay after request.
  task automatic txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                     input logic [SW-1:0] wstrb, input int lat_a, input int lat_w, input int lat_r,
                     input logic [1:0] resp, input int hold, input bit overlap, input bit abort);
    int c = 1;
    int a_e = -1, w_e = -1, b_e = -1, r_e = -1, rsp_c = -1, a_n = 0, w_n = 0, exp_c, hs;
    logic [AW-1:0] cap_addr = '0;
    logic [DW-1:0] cap_data = '0, exp_rdata;
    logic [SW-1:0] cap_strb = '0;
    check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb;
    @(posedge axi_clock); @(negedge axi_clock);
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    check("cmd_ready_busy", 64'(cmd_ready), 64'(0));
    while (rsp_c < 0 && c < 200) begin
      if (rsp_valid) begin
        rsp_c = c;
      end else begin
        if (we) begin
          if (abort && m_axil_bready) begin
            rst = 1'b1; slave_idle();
            @(posedge axi_clock); @(negedge axi_clock);
            rst = 1'b0;
            check_reset_outputs("abort");
            return;
          end
          m_axil_awready = (c >= 1 + lat_a);
          m_axil_wready  = (c >= 1 + lat_w);
          m_axil_bresp   = resp;
          m_axil_bvalid  = (a_e >= 0 && w_e >= 0 && b_e < 0 &&
                            c >= ((a_e > w_e) ? a_e : w_e) + 1 + lat_r);
          if (m_axil_awvalid) check("awaddr_stable", 64'(m_axil_awaddr), 64'(addr));
          if (m_axil_wvalid) check("wdata_stable", 64'({m_axil_wdata, m_axil_wstrb}), 64'({wdata, wstrb}));
          if (m_axil_awvalid && m_axil_awready) begin a_n++; a_e = c; cap_addr = m_axil_awaddr; end
          if (m_axil_wvalid && m_axil_wready) begin
            w_n++; w_e = c; cap_data = m_axil_wdata; cap_strb = m_axil_wstrb;
          end
          if (m_axil_bvalid && m_axil_bready) begin
            b_e = c;
            if (resp == 2'b00)
              for (int i = 0; i < SW; i++)
                if (cap_strb[i]) slv_mem[cap_addr[AW-1:2]][8*i +: 8] = cap_data[8*i +: 8];
          end
        end else begin
          m_axil_arready = (c >= 1 + lat_a);
          m_axil_rvalid  = (a_e >= 0 && r_e < 0 && c >= a_e + 1 + lat_r);
          m_axil_rdata   = m_axil_rvalid ? slv_mem[cap_addr[AW-1:2]] : '0;
          m_axil_rresp   = resp;
          if (m_axil_arvalid) check("araddr_stable", 64'(m_axil_araddr), 64'(addr));
          if (m_axil_arvalid && m_axil_arready) begin a_n++; a_e = c; cap_addr = m_axil_araddr; end
          if (m_axil_rvalid && m_axil_rready) r_e = c;
        end
        @(posedge axi_clock); @(negedge axi_clock);
        c++;
      end
    end
    slave_idle();
    check("rsp_seen", 64'(rsp_valid), 64'(1));
    // Reference: request handshakes once the ready delay expires, response one cycle later.
    hs = we ? ((lat_a > lat_w) ? lat_a : lat_w) : lat_a;
    exp_c = 1 + hs + 1 + lat_r + 1;
    exp_rdata = we ? '0 : ref_mem[addr[AW-1:2]];
    if (we && resp == 2'b00)
      for (int i = 0; i < SW; i++)
        if (wstrb[i]) ref_mem[addr[AW-1:2]][8*i +: 8] = wdata[8*i +: 8];
    check("rsp_cycle", 64'(rsp_c), 64'(exp_c));
    check("addr_handshakes", 64'(a_n), 64'(1));
    check("addr_captured", 64'(cap_addr), 64'(addr));
    if (we) begin
      check("w_handshakes", 64'(w_n), 64'(1));
      check("w_captured", 64'({cap_data, cap_strb}), 64'({wdata, wstrb}));
    end
    check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
    check("rsp_resp", 64'(rsp_resp), 64'(resp));
    check("rsp_timeout", 64'(rsp_timeout), 64'(0));
    check("cmd_ready_rsp", 64'(cmd_ready), 64'(0));
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      @(posedge axi_clock); @(negedge axi_clock);
      check("hold_valid", 64'(rsp_valid), 64'(1));
      check("hold_fields", 64'({rsp_rdata, rsp_resp}), 64'({exp_rdata, resp}));
      check("hold_cmd_ready", 64'(cmd_ready), 64'(0));
    end
    rsp_ready = 1'b1;
    if (overlap) begin
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = addr ^ 12'h0F0; cmd_wdata = ~wdata; cmd_wstrb = '1;
    end
    @(posedge axi_clock); @(negedge axi_clock);
    rsp_ready = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0;
    check("rsp_released", 64'(rsp_valid), 64'(0));
    check("cmd_ready_back", 64'(cmd_ready), 64'(1));
    check("no_early_request", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin ref_mem[i] = '0; slv_mem[i] = '0; end
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    slave_idle();
    repeat (3) @(posedge axi_clock);
    @(negedge axi_clock);
    check_reset_outputs("reset");
    check("prot", 64'({m_axil_awprot, m_axil_arprot}), 64'(0));
    rst = 1'b0;
    @(negedge axi_clock);

    txn(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 0, 1'b0, 1'b0);
    txn(1'b1, 12'h004, 32'h12345678, 4'hF, 0, 0, 0, 2'b00, 0, 1'b0, 1'b0);
    txn(1'b0, 12'h004, '0, '0, 0, 0, 0, 2'b00, 0, 1'b0, 1'b0);
    txn(1'b1, 12'h008, 32'hA5A5F00D, 4'hF, 5, 0, 1, 2'b00, 0, 1'b0, 1'b0);
    txn(1'b1, 12'h00C, 32'h0BADCAFE, 4'h5, 0, 5, 2, 2'b00, 0, 1'b0, 1'b0);
    txn(1'b0, 12'h00C, '0, '0, 2, 0, 3, 2'b00, 0, 1'b0, 1'b0);
    txn(1'b0, 12'h010, '0, '0, 1, 0, 1, 2'b10, 10, 1'b1, 1'b0);
    txn(1'b1, 12'h020, 32'h77777777, 4'hF, 0, 0, 20, 2'b00, 0, 1'b0, 1'b1);
    txn(1'b0, 12'h020, '0, '0, 0, 0, 0, 2'b00, 0, 1'b0, 1'b0);
    txn(1'b0, 12'h008, '0, '0, 0, 0, 0, 2'b00, 0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic          r_we;
      logic [AW-1:0] r_addr;
      logic [1:0]    r_resp;
      r_we   = 1'($urandom_range(0, 1));
      r_addr = AW'($urandom_range(0, 31));
      r_resp = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00;
      txn(r_we, r_addr, DW'($urandom), SW'($urandom_range(0, 15)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          r_resp, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
